// File: rtl/hand_pkg.sv
// Shared types, gesture codes and the gesture-to-target lookup for the bionic hand.
package hand_pkg;

  localparam int NUM_FINGERS = 5;

  localparam logic [15:0] DEF_MIN_US     = 16'd1000;
  localparam logic [15:0] DEF_MAX_US     = 16'd2000;
  localparam logic [15:0] DEF_NEUTRAL_US = 16'd1500;

  typedef enum logic [2:0] {THUMB, INDEX, MIDDLE, RING, PINKY} finger_e;

  localparam logic [7:0] G_NEUTRAL = 8'h01;
  localparam logic [7:0] G_RELAX   = 8'h02;
  localparam logic [7:0] G_FIST    = 8'h04;
  localparam logic [7:0] G_OPEN    = 8'h08;
  localparam logic [7:0] G_POINT   = 8'h10;

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, HOLD} state_e;

  typedef logic [NUM_FINGERS-1:0][15:0] width_arr_t;

  // Unrecognised codes (zero, multi-hot, unused bits) fall back to neutral.
  function automatic width_arr_t gesture_targets(input logic [7:0]  code,
                                                 input logic [15:0] min_us     = DEF_MIN_US,
                                                 input logic [15:0] max_us     = DEF_MAX_US,
                                                 input logic [15:0] neutral_us = DEF_NEUTRAL_US);
    width_arr_t t;
    case (code)
      G_NEUTRAL: t = {NUM_FINGERS{16'd1500}};
      G_RELAX:   t = {NUM_FINGERS{16'd1400}};
      G_FIST:    t = {NUM_FINGERS{min_us}};
      G_OPEN:    t = {NUM_FINGERS{max_us}};
      G_POINT: begin
        t = {NUM_FINGERS{min_us}};
        t[INDEX] = max_us;
      end
      default:   t = {NUM_FINGERS{neutral_us}};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running servo frame counter; tick is high for the last cycle of each frame.
module frame_tick_gen #(
  parameter int FRAME_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/finger_motion_sequencer.sv
// Accepts gesture codes and slews five finger servo widths toward their targets,
// one bounded step per servo frame.
module finger_motion_sequencer
  import hand_pkg::*;
#(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int STEP_US      = 10,
  parameter int MIN_US       = 1000,
  parameter int MAX_US       = 2000,
  parameter int NEUTRAL_US   = 1500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gesture_valid,
  input  logic [7:0]  gesture,
  output logic        gesture_ready,
  output logic [15:0] width_thumb,
  output logic [15:0] width_index,
  output logic [15:0] width_middle,
  output logic [15:0] width_ring,
  output logic [15:0] width_pinky,
  output logic        busy,
  output logic        settled,
  output logic        frame_tick
);

  localparam logic [15:0] STEP_W    = 16'(STEP_US);
  localparam logic [15:0] MIN_W     = 16'(MIN_US);
  localparam logic [15:0] MAX_W     = 16'(MAX_US);
  localparam logic [15:0] NEUTRAL_W = 16'(NEUTRAL_US);

  function automatic logic [15:0] clamp_us(input logic [15:0] v);
    if (v < MIN_W)      return MIN_W;
    else if (v > MAX_W) return MAX_W;
    else                return v;
  endfunction

  state_e     state_reg;
  logic [7:0] code_reg;
  logic       ready_reg, busy_reg, settled_reg;
  width_arr_t target_reg, width_reg, width_next, raw_targets, load_targets;
  logic [NUM_FINGERS-1:0] at_target_next, differs_load;
  logic       accept, step_en;

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (frame_tick)
  );

  assign accept      = gesture_valid & ready_reg;
  assign step_en     = (state_reg == RAMP) && frame_tick;
  assign raw_targets = gesture_targets(code_reg, MIN_W, MAX_W, NEUTRAL_W);

  // Compare before subtracting so the unsigned difference never wraps.
  for (genvar gi = 0; gi < NUM_FINGERS; gi++) begin : g_finger
    logic [15:0] stepped;
    always_comb begin
      stepped = width_reg[gi];
      if (target_reg[gi] > width_reg[gi]) begin
        stepped = (target_reg[gi] - width_reg[gi] <= STEP_W) ? target_reg[gi]
                                                             : width_reg[gi] + STEP_W;
      end else if (target_reg[gi] < width_reg[gi]) begin
        stepped = (width_reg[gi] - target_reg[gi] <= STEP_W) ? target_reg[gi]
                                                             : width_reg[gi] - STEP_W;
      end
    end
    assign width_next[gi]     = step_en ? stepped : width_reg[gi];
    assign load_targets[gi]   = clamp_us(raw_targets[gi]);
    assign at_target_next[gi] = (width_next[gi] == target_reg[gi]);
    assign differs_load[gi]   = (width_reg[gi] != load_targets[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_reg <= {NUM_FINGERS{NEUTRAL_W}};
    end else begin
      width_reg <= width_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      code_reg    <= 8'h00;
      target_reg  <= {NUM_FINGERS{NEUTRAL_W}};
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      settled_reg <= 1'b0;
    end else begin
      settled_reg <= 1'b0;
      case (state_reg)
        IDLE, HOLD: begin
          if (accept) begin
            state_reg <= LOAD;
            code_reg  <= gesture;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          target_reg <= load_targets;
          ready_reg  <= 1'b1;
          if (|differs_load) begin
            state_reg <= RAMP;
            busy_reg  <= 1'b1;
          end else begin
            state_reg   <= HOLD;
            busy_reg    <= 1'b0;
            settled_reg <= 1'b1;
          end
        end
        RAMP: begin
          // A same-cycle step still lands toward the old targets before retargeting.
          if (accept) begin
            state_reg <= LOAD;
            code_reg  <= gesture;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end else if (step_en && (&at_target_next)) begin
            state_reg   <= HOLD;
            busy_reg    <= 1'b0;
            settled_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gesture_ready = ready_reg;
  assign busy          = busy_reg;
  assign settled       = settled_reg;
  assign width_thumb   = width_reg[THUMB];
  assign width_index   = width_reg[INDEX];
  assign width_middle  = width_reg[MIDDLE];
  assign width_ring    = width_reg[RING];
  assign width_pinky   = width_reg[PINKY];

endmodule

// File: doc/finger_motion_sequencer.md
# finger_motion_sequencer

Sequences the five finger servo channels of the bionic hand. It accepts gesture codes through a valid/ready handshake and looks up per-finger target pulse widths. It then slews each finger's commanded width toward its target by a bounded step once per servo frame. Its five width outputs drive the per-finger `servo_pwm` instances directly, replacing the instantaneous width switching with rate-limited motion.

## Interface
- `FRAME_CYCLES`, 1_000_000: clock cycles per servo frame (20 ms at 50 MHz); one ramp step per frame.
- `STEP_US`, 10: maximum width change per finger per frame, in µs.
- `MIN_US`, 1000: lowest permitted width; targets are clamped to it.
- `MAX_US`, 2000: highest permitted width; targets are clamped to it.
- `NEUTRAL_US`, 1500: reset and unknown-gesture width.
- `clk  in  1`: system clock.
- `rst_n  in  1`: reset. One clock; reset is asynchronous and active-low.
- `gesture_valid  in  1`: `gesture` holds a new code.
- `gesture  in  8`: one-hot gesture code.
- `gesture_ready  out  1`: block can accept a code this cycle.
- `width_thumb`, `width_index`, `width_middle`, `width_ring`, `width_pinky  out  16 each`: commanded pulse width in µs, to `servo_pwm.width_us`.
- `busy  out  1`: high while any finger differs from its target.
- `settled  out  1`: one-cycle pulse when all fingers reach target.
- `frame_tick  out  1`: one-cycle pulse at each frame boundary.

## Operation
- States: `IDLE`, `LOAD`, `RAMP`, `HOLD`. Reset enters `IDLE`.
- Reset values:
  - all widths and targets = `NEUTRAL_US`;
  - `busy` = 0, `settled` = 0, `frame_tick` = 0;
  - `gesture_ready` = 1;
  - frame counter = 0.
- `gesture_ready` = 1 in `IDLE`, `RAMP` and `HOLD`; = 0 in `LOAD`.
- Accept occurs on `gesture_valid & gesture_ready`. The code is latched and the next state is `LOAD` from any accepting state.
- `LOAD` lasts 1 cycle. Targets are registered from the gesture table, each clamped to [`MIN_US`, `MAX_US`].
  - Next state is `RAMP` if any width differs from its target.
  - Otherwise next state is `HOLD` and `settled` pulses on entry.
- Gesture table:
  - 0x01 → all fingers 1500
  - 0x02 → all fingers 1400
  - 0x04 (fist) → all fingers `MIN_US`
  - 0x08 (open) → all fingers `MAX_US`
  - 0x10 (point) → index `MAX_US`, other fingers `MIN_US`
  - any other code, including 0x00 and multi-hot → all fingers `NEUTRAL_US`
- `RAMP`: on each `frame_tick`, every finger updates independently.
  - If |target − width| ≤ `STEP_US`, width = target.
  - Otherwise width moves by `STEP_US` toward target.
- Arithmetic is unsigned 16-bit with the comparison done before subtraction; no wrap is possible since all values lie in [`MIN_US`, `MAX_US`].
- Leaving `RAMP`: when all widths equal their targets after a step, next state is `HOLD` and `settled` pulses for 1 cycle.
- `busy` = (state == `RAMP`) or (state == `LOAD`).
- `HOLD` keeps widths static until the next accept.

## Timing
- Frame counter runs freely from reset, counting 0..`FRAME_CYCLES`−1.
  - `frame_tick` is asserted in the cycle the counter equals `FRAME_CYCLES`−1; the counter then wraps to 0.
  - The counter is unaffected by state or gestures.
- Widths are registered outputs; a width changes on the clock edge that samples `frame_tick` high in `RAMP`.
- Accept → `LOAD` takes 1 cycle. The first width change happens at the first `frame_tick` seen in `RAMP`, at most `FRAME_CYCLES`+1 cycles after `LOAD`.
- A `frame_tick` during `LOAD` is dropped (no step); the step resumes on the next frame.
- Accept and `frame_tick` in the same `RAMP` cycle: the step is applied toward the old targets, then `LOAD` retargets. No width jumps; motion continues from the current widths.
- Re-accepting the same gesture while in `HOLD`: `LOAD` → `HOLD` with a `settled` pulse 2 cycles after accept.
- `rst_n` low mid-ramp: all widths return to `NEUTRAL_US` immediately (asynchronously) and the state goes to `IDLE`.
- Worst-case slew for a full span is (`MAX_US`−`MIN_US`)/`STEP_US` = 100 frames (2 s).

## Structure
- Shared package `hand_pkg` contains:
  - `NUM_FINGERS` = 5;
  - finger index enum (`THUMB`..`PINKY`);
  - gesture code localparams;
  - state enum;
  - function `gesture_targets(code)` returning a 5×16 target array.
- Sub-module `frame_tick_gen` (parameter `FRAME_CYCLES`; ports `clk`, `rst_n`, `tick`) holds the free-running counter.
- Per-finger step logic is a generate loop over `NUM_FINGERS`.

## Test plan
All scenarios use `FRAME_CYCLES`=100 for simulation.
- Reset release, no gestures: all widths = 1500, `busy`=0, `ready`=1, `frame_tick` every 100 cycles.
- Gesture 0x02 from neutral: widths step 1490, 1480, …, reaching 1400 on the 10th tick; `settled` pulses once; `busy` drops in the same cycle.
- Gesture 0x10 from neutral: index reaches 2000 and other fingers reach 1000 on the 50th tick; all fingers move on the same ticks.
- Gesture 0x04 accepted, then 0x08 accepted after 5 ticks (widths at 1450): widths rise from 1450 and reach 2000 on the 55th further tick; no discontinuity greater than 10.
- Unknown code 0x80 while in `HOLD` at 1400: ramps back to 1500 in 10 ticks; same code re-sent in `HOLD` gives `settled` 2 cycles later with widths unchanged.
- `rst_n` pulsed low mid-ramp at 1200: widths read 1500 while reset is low, state `IDLE`, no `settled` pulse.
